// File: rtl/rv_mc_main_ctrl_v2_if.sv
// Control bundle between the main control FSM (master) and the multi-cycle
// datapath/memory (slave): opcode and memory handshake in, selects and strobes out.
interface rv_mc_main_ctrl_v2_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic             mem_ready;
    logic             PCUpdate;
    logic             adrSrc;
    logic             memRead;
    logic             memWrite;
    logic             branch;
    logic             IRWrite;
    logic             regWrite;
    logic [1:0]       resultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [2:0]       immSrc;
    logic             illegal;
    logic             halted;
    logic [CNT_W-1:0] instret;
    logic [4:0]       state;

    modport master (
        input  op, mem_ready,
        output PCUpdate, adrSrc, memRead, memWrite, branch, IRWrite, regWrite,
               resultSrc, ALUSrcA, ALUSrcB, ALUOp, immSrc, illegal, halted, instret, state
    );

    modport slave (
        output op, mem_ready,
        input  PCUpdate, adrSrc, memRead, memWrite, branch, IRWrite, regWrite,
               resultSrc, ALUSrcA, ALUSrcB, ALUOp, immSrc, illegal, halted, instret, state
    );
endinterface

// File: rtl/rv_mc_main_ctrl_v2.sv
// Main control FSM for the multi-cycle RV32I core: Moore decode of datapath
// selects and strobes, memory wait-states, illegal-opcode trap, retired counter.
module rv_mc_main_ctrl_v2 #(
    parameter bit MEM_WAIT_EN     = 1'b1,
    parameter bit ENABLE_JALR     = 1'b1,
    parameter bit ENABLE_AUIPC    = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input logic                  clk,
    input logic                  rst,
    rv_mc_main_ctrl_v2_if.master bus
);
    typedef enum logic [4:0] {
        FETCH, DECODE, EX_R, EX_I, EX_L, EX_S, EX_B, EX_J, EX_JR, EX_U,
        EX_AUIPC, ALU_WB, MEM_RD, MEM_WB, MEM_WR, LINK_WB, TRAP
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             rdy, bad;
    logic             pc_update, adr_src, mem_read, mem_write, branch, ir_write, reg_write;
    logic             illegal, halted;
    logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0]       imm_src;

    assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != FETCH && state_q != TRAP && state_d == FETCH)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case can leave a value held (which would infer a latch).
        state_d    = state_q;
        bad        = 1'b0;
        pc_update  = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        imm_src    = 3'b000;

        unique case (state_q)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = rdy;
                pc_update  = rdy;
                if (rdy) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                case (bus.op)
                    OP_R:     state_d = EX_R;
                    OP_I:     state_d = EX_I;
                    OP_LOAD:  state_d = EX_L;
                    OP_STORE: state_d = EX_S;
                    OP_BR:    state_d = EX_B;
                    OP_JAL:   state_d = EX_J;
                    OP_LUI:   state_d = EX_U;
                    OP_JALR:  if (ENABLE_JALR) state_d = EX_JR; else bad = 1'b1;
                    OP_AUIPC: if (ENABLE_AUIPC) state_d = EX_AUIPC; else bad = 1'b1;
                    default:  bad = 1'b1;
                endcase
                if (bad) begin
                    state_d = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                    illegal = !TRAP_ON_ILLEGAL;
                end
            end
            EX_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            EX_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
                state_d   = ALU_WB;
            end
            EX_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            EX_L: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = MEM_RD;
            end
            MEM_RD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (rdy) state_d = MEM_WB;
            end
            MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            EX_S: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = 3'b001;
                state_d   = MEM_WR;
            end
            MEM_WR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (rdy) state_d = FETCH;
            end
            EX_B: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            EX_J: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                imm_src    = 3'b011;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = LINK_WB;
            end
            EX_JR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = LINK_WB;
            end
            LINK_WB: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            EX_U: begin
                imm_src    = 3'b100;
                result_src = 2'b11;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
                halted  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are masked while reset is asserted so an aborted access never
    // leaves a read, write or register update visible.
    assign bus.PCUpdate  = rst & pc_update;
    assign bus.adrSrc    = rst & adr_src;
    assign bus.memRead   = rst & mem_read;
    assign bus.memWrite  = rst & mem_write;
    assign bus.branch    = rst & branch;
    assign bus.IRWrite   = rst & ir_write;
    assign bus.regWrite  = rst & reg_write;
    assign bus.illegal   = rst & illegal;
    assign bus.halted    = rst & halted;
    assign bus.resultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.immSrc    = imm_src;
    assign bus.instret   = instret_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_rv_mc_main_ctrl_v2.sv
// Bench for rv_mc_main_ctrl_v2: three parameter variants driven per instruction,
// every cycle compared against a per-opcode phase list built from the encodings.
module tb_rv_mc_main_ctrl_v2;
    localparam int N = 3;

    typedef struct packed {
        logic [6:0] s;     // {PCUpdate, adrSrc, memRead, memWrite, branch, IRWrite, regWrite}
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [2:0] imm;
        logic       ill;
        logic       hlt;
    } ctl_t;

    typedef struct packed {
        ctl_t exp;
        bit   waits;
    } phase_t;

    localparam logic [6:0] S_PC  = 7'b1000000;
    localparam logic [6:0] S_ADR = 7'b0100000;
    localparam logic [6:0] S_RD  = 7'b0010000;
    localparam logic [6:0] S_WR  = 7'b0001000;
    localparam logic [6:0] S_BR  = 7'b0000100;
    localparam logic [6:0] S_IR  = 7'b0000010;
    localparam logic [6:0] S_RW  = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Variant 0: defaults; 1: skip-illegal, 4-bit counter; 2: no waits, no JALR/AUIPC, trap.
    bit cfg_wait  [N] = '{1'b1, 1'b1, 1'b0};
    bit cfg_jalr  [N] = '{1'b1, 1'b1, 1'b0};
    bit cfg_auipc [N] = '{1'b1, 1'b1, 1'b0};
    bit cfg_trap  [N] = '{1'b1, 1'b0, 1'b1};
    int cfg_w     [N] = '{32, 4, 32};

    logic [6:0]  op_v    [N];
    logic        rdy_v   [N];
    ctl_t        obs     [N];
    logic [31:0] cnt_obs [N];
    longint      exp_cnt [N];

    int n_checks = 0;
    int n_err    = 0;

    phase_t seq[$];
    int     kind;   // 0 legal, 1 skipped illegal, 2 trapped

    rv_mc_main_ctrl_v2_if #(.CNT_W(32)) if_a ();
    rv_mc_main_ctrl_v2_if #(.CNT_W(4))  if_b ();
    rv_mc_main_ctrl_v2_if #(.CNT_W(32)) if_c ();

    rv_mc_main_ctrl_v2 dut_a (.clk(clk), .rst(rst_n), .bus(if_a));
    rv_mc_main_ctrl_v2 #(.MEM_WAIT_EN(1'b1), .ENABLE_JALR(1'b1), .ENABLE_AUIPC(1'b1),
                         .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4))
        dut_b (.clk(clk), .rst(rst_n), .bus(if_b));
    rv_mc_main_ctrl_v2 #(.MEM_WAIT_EN(1'b0), .ENABLE_JALR(1'b0), .ENABLE_AUIPC(1'b0),
                         .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32))
        dut_c (.clk(clk), .rst(rst_n), .bus(if_c));

    assign if_a.op = op_v[0];
    assign if_b.op = op_v[1];
    assign if_c.op = op_v[2];
    assign if_a.mem_ready = rdy_v[0];
    assign if_b.mem_ready = rdy_v[1];
    assign if_c.mem_ready = rdy_v[2];

    assign obs[0] = {if_a.PCUpdate, if_a.adrSrc, if_a.memRead, if_a.memWrite, if_a.branch,
                     if_a.IRWrite, if_a.regWrite, if_a.resultSrc, if_a.ALUSrcA, if_a.ALUSrcB,
                     if_a.ALUOp, if_a.immSrc, if_a.illegal, if_a.halted};
    assign obs[1] = {if_b.PCUpdate, if_b.adrSrc, if_b.memRead, if_b.memWrite, if_b.branch,
                     if_b.IRWrite, if_b.regWrite, if_b.resultSrc, if_b.ALUSrcA, if_b.ALUSrcB,
                     if_b.ALUOp, if_b.immSrc, if_b.illegal, if_b.halted};
    assign obs[2] = {if_c.PCUpdate, if_c.adrSrc, if_c.memRead, if_c.memWrite, if_c.branch,
                     if_c.IRWrite, if_c.regWrite, if_c.resultSrc, if_c.ALUSrcA, if_c.ALUSrcB,
                     if_c.ALUOp, if_c.immSrc, if_c.illegal, if_c.halted};
    assign cnt_obs[0] = if_a.instret;
    assign cnt_obs[1] = {28'd0, if_b.instret};
    assign cnt_obs[2] = if_c.instret;

    function automatic ctl_t mk(input logic [6:0] s, input logic [1:0] res, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] aop, input logic [2:0] imm,
                                input logic ill = 1'b0, input logic hlt = 1'b0);
        return {s, res, a, b, aop, imm, ill, hlt};
    endfunction

    function automatic ctl_t fetch_vec(input bit eff);
        return mk(S_RD | (eff ? (S_PC | S_IR) : 7'd0), 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    endfunction

    function automatic void add(input ctl_t e, input bit w = 1'b0);
        phase_t p;
        p.exp   = e;
        p.waits = w;
        seq.push_back(p);
    endfunction

    // Phases after DECODE for one opcode on variant k.
    function automatic void build(input int k, input logic [6:0] op);
        ctl_t alu_wb;
        ctl_t link_wb;
        alu_wb  = mk(S_RW, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        link_wb = mk(S_RW, 2'b10, 2'b01, 2'b10, 2'b00, 3'b000);
        seq.delete();
        kind = 0;
        case (op)
            7'b0110011: begin add(mk(7'd0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000)); add(alu_wb); end
            7'b0010011: begin add(mk(7'd0, 2'b00, 2'b10, 2'b01, 2'b11, 3'b000)); add(alu_wb); end
            7'b0000011: begin
                add(mk(7'd0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
                add(mk(S_ADR | S_RD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 1'b1);
                add(mk(S_RW, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));
            end
            7'b0100011: begin
                add(mk(7'd0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001));
                add(mk(S_ADR | S_WR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 1'b1);
            end
            7'b1100011: add(mk(S_BR, 2'b00, 2'b10, 2'b00, 2'b01, 3'b000));
            7'b1101111: begin add(mk(S_PC, 2'b10, 2'b01, 2'b01, 2'b00, 3'b011)); add(link_wb); end
            7'b1100111:
                if (cfg_jalr[k]) begin add(mk(S_PC, 2'b10, 2'b10, 2'b01, 2'b00, 3'b000)); add(link_wb); end
                else kind = cfg_trap[k] ? 2 : 1;
            7'b0110111: add(mk(S_RW, 2'b11, 2'b00, 2'b00, 2'b00, 3'b100));
            7'b0010111:
                if (cfg_auipc[k]) begin add(mk(7'd0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100)); add(alu_wb); end
                else kind = cfg_trap[k] ? 2 : 1;
            default: kind = cfg_trap[k] ? 2 : 1;
        endcase
    endfunction

    task automatic check_ctl(input string tag, input int k, input ctl_t exp);
        n_checks++;
        assert (obs[k] === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d: observed=%b expected=%b", tag, k, obs[k], exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int k);
        logic [31:0] e;
        e = 32'(exp_cnt[k]);
        n_checks++;
        assert (cnt_obs[k] === e) else begin
            n_err++;
            $error("FAIL %s dut%0d instret: observed=%0d expected=%0d", tag, k, cnt_obs[k], e);
        end
    endtask

    // Enters at posedge+1; leaves at posedge+1 of the cycle after the phase ends.
    task automatic run_phase(input string tag, input int k, input ctl_t exp, input bit waits,
                             input bit is_fetch, input int lows);
        int n;
        n = waits ? lows : 0;
        for (int i = 0; i <= n; i++) begin
            bit eff;
            rdy_v[k] = waits ? (i == n) : 1'($urandom_range(0, 1));
            eff = rdy_v[k] | !cfg_wait[k];
            #1;
            check_ctl(tag, k, is_fetch ? fetch_vec(eff) : exp);
            @(posedge clk);
            #1;
            if (eff) break;
        end
    endtask

    // Low-cycle counts of -1 are drawn at random.
    task automatic run_instr(input int k, input logic [6:0] op, input int fetch_lo, input int mem_lo);
        string tag;
        int    lows;
        tag = $sformatf("op%b", op);
        op_v[k] = op;
        build(k, op);
        lows = (fetch_lo < 0) ? int'($urandom_range(0, 2)) : fetch_lo;
        run_phase({tag, "/fetch"}, k, fetch_vec(1'b1), 1'b1, 1'b1, lows);
        check_cnt({tag, "/cnt_in_decode"}, k);
        run_phase({tag, "/decode"}, k,
                  mk(7'd0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, kind == 1), 1'b0, 1'b0, 0);
        if (kind == 2) begin
            for (int i = 0; i < 3; i++)
                run_phase({tag, "/trap"}, k,
                          mk(7'd0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1), 1'b0, 1'b0, 0);
            check_cnt({tag, "/cnt_trap"}, k);
        end else begin
            foreach (seq[i]) begin
                lows = (mem_lo < 0) ? int'($urandom_range(0, 2)) : mem_lo;
                run_phase($sformatf("%s/ph%0d", tag, i), k, seq[i].exp, seq[i].waits, 1'b0, lows);
            end
            exp_cnt[k] = (exp_cnt[k] + 1) % (longint'(1) << cfg_w[k]);
            check_cnt({tag, "/instret"}, k);
        end
        rdy_v[k] = 1'b0;
    endtask

    // Leaves at posedge+1 with reset released and every variant in FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            rdy_v[k]   = 1'b0;
            op_v[k]    = 7'b0110111;
            exp_cnt[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [6:0] pool_a [9]  = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [6:0] pool_b [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111,
                                7'b0000000};

    initial begin
        do_reset();
        #1;
        check_ctl("reset_state", 0, fetch_vec(1'b0));
        check_ctl("reset_state", 1, fetch_vec(1'b0));
        check_ctl("reset_state", 2, fetch_vec(1'b1));
        for (int k = 0; k < N; k++) check_cnt("reset_instret", k);
        do_reset();

        // Directed sequences on the default variant.
        run_instr(0, 7'b0110011, 0, 0);   // ADD
        run_instr(0, 7'b0000011, 2, 3);   // LW with FETCH and MEM_RD waits
        run_instr(0, 7'b0100011, 0, 1);   // SW with one MEM_WR wait
        run_instr(0, 7'b1100111, 0, 0);   // JALR
        run_instr(0, 7'b0010111, 1, 0);   // AUIPC
        for (int i = 0; i < 40; i++)
            run_instr(0, pool_a[$urandom_range(0, 8)], -1, -1);

        // No-wait variant ignores mem_ready, then JALR traps and halts.
        do_reset();
        run_instr(2, 7'b0000011, 2, 2);
        run_instr(2, 7'b0100011, 0, 2);
        run_instr(2, 7'b1100111, 0, 0);

        // Skipped illegal opcode, then reset aborts a stalled load.
        do_reset();
        run_instr(1, 7'b1111111, 0, 0);
        op_v[1]  = 7'b0000011;
        rdy_v[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rdy_v[1] = 1'b0;
        #1;
        check_ctl("lw_abort/mem_rd", 1, mk(S_ADR | S_RD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) exp_cnt[k] = 0;
        check_ctl("lw_abort/in_reset", 1, mk(7'd0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        check_cnt("lw_abort/in_reset", 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(1, 7'b0110011, 0, 0);

        // 4-bit counter wraps after 16 LUIs.
        do_reset();
        for (int i = 0; i < 17; i++)
            run_instr(1, 7'b0110111, -1, 0);
        for (int i = 0; i < 30; i++)
            run_instr(1, pool_b[$urandom_range(0, 10)], -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/rv_mc_main_ctrl_v2.md
Name: rv_mc_main_ctrl_v2

Overview:
Parametrised next-generation main control FSM for the multi-cycle RV32I core. It adds JALR, AUIPC, memory wait-states via a mem_ready handshake, explicit memRead, an illegal-opcode trap/halt, and a retired-instruction counter. It drives the same multi-cycle datapath select encodings and sits between the instruction register opcode field and the datapath/memory controls.

Parameters:
MEM_WAIT_EN, 1, 1: fetch and memory states hold until mem_ready=1; 0: mem_ready is ignored and treated as 1.
ENABLE_JALR, 1, decode opcode 1100111 as JALR; 0: the opcode is illegal.
ENABLE_AUIPC, 1, decode opcode 0010111 as AUIPC; 0: the opcode is illegal.
TRAP_ON_ILLEGAL, 1, 1: an illegal opcode enters TRAP and halts; 0: pulse illegal for one cycle and return to FETCH.
CNT_W, 32, width of instret.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
op  in  7  opcode from instruction register
mem_ready  in  1  memory access completes this cycle
PCUpdate, adrSrc, memRead, memWrite, branch, IRWrite, regWrite  out  1 each
resultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2 each
immSrc  out  3
illegal  out  1  illegal opcode flag
halted  out  1  FSM is in TRAP
instret  out  CNT_W  retired-instruction count
state  out  5  current state, debug

Behaviour:
- Encodings:
  - ALUSrcA: 00 PC, 01 OldPC, 10 RS1.
  - ALUSrcB: 00 RS2, 01 imm, 10 const 4.
  - resultSrc: 00 ALUOut, 01 MemData, 10 ALUResult, 11 imm.
  - immSrc: 000 I, 001 S, 010 B, 011 J, 100 U.
  - ALUOp: 00 add, 01 branch compare, 10 R-funct, 11 I-funct.
- Outputs are Moore and combinational from state (plus mem_ready where noted). Every output not listed for a state is 0.
- Reset (rst=0, asynchronous): state=FETCH, instret=0, illegal=0. All outputs then take their FETCH values.
- FETCH:
  - adrSrc=0, memRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, resultSrc=10.
  - IRWrite=PCUpdate=mem_ready.
  - Stay in FETCH while mem_ready=0; otherwise go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, immSrc=010, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0110011 -> EX_R
  - 0010011 -> EX_I
  - 0000011 -> EX_L
  - 0100011 -> EX_S
  - 1100011 -> EX_B
  - 1101111 -> EX_J
  - 1100111 -> EX_JR
  - 0110111 -> EX_U
  - 0010111 -> EX_AUIPC
  - any other opcode (or a disabled one) -> TRAP if TRAP_ON_ILLEGAL, else FETCH with illegal=1 for that DECODE cycle only.
- Execute and write-back states:
  - EX_R: A=10, B=00, ALUOp=10 -> ALU_WB.
  - EX_I: A=10, B=01, immSrc=000, ALUOp=11 -> ALU_WB.
  - EX_AUIPC: A=01, B=01, immSrc=100, ALUOp=00 -> ALU_WB.
  - ALU_WB: resultSrc=00, regWrite=1 -> FETCH.
  - EX_L: A=10, B=01, immSrc=000, ALUOp=00 -> MEM_RD.
  - MEM_RD: adrSrc=1, memRead=1, resultSrc=00. Hold while mem_ready=0, then -> MEM_WB.
  - MEM_WB: resultSrc=01, regWrite=1 -> FETCH.
  - EX_S: A=10, B=01, immSrc=001, ALUOp=00 -> MEM_WR.
  - MEM_WR: adrSrc=1, memWrite=1, resultSrc=00. Hold (memWrite stays 1) until mem_ready, then -> FETCH.
  - EX_B: A=10, B=00, ALUOp=01, resultSrc=00, branch=1 -> FETCH.
  - EX_J: A=01, B=01, immSrc=011, ALUOp=00, resultSrc=10, PCUpdate=1 -> LINK_WB.
  - EX_JR: A=10, B=01, immSrc=000, ALUOp=00, resultSrc=10, PCUpdate=1 -> LINK_WB.
  - LINK_WB: A=01, B=10, ALUOp=00, resultSrc=10, regWrite=1 (rd=OldPC+4) -> FETCH.
  - EX_U: immSrc=100, resultSrc=11, regWrite=1 -> FETCH.
- TRAP: illegal=1 and halted=1, all strobes 0. Exit only by reset.
- Cycle counts with mem_ready always 1 (including FETCH):
  - R, I, AUIPC, S, JAL, JALR: 4.
  - Load: 5.
  - Branch, LUI: 3.
  - Each mem_ready=0 cycle adds one cycle.
- instret:
  - Increments by 1 on every clock edge that enters FETCH from a non-FETCH state other than TRAP. An illegal instruction skipped with TRAP_ON_ILLEGAL=0 also counts.
  - Wraps modulo 2^CNT_W.
- With MEM_WAIT_EN=0, mem_ready is internally forced to 1.
- Reset asserted mid-instruction aborts immediately; no strobe may remain high during reset.

Test Plan:
- ADD (op=0110011), mem_ready=1: states FETCH, DECODE, EX_R, ALU_WB, FETCH. regWrite=1 only in ALU_WB with resultSrc=00. instret goes 0 to 1 after 4 cycles.
- LW (op=0000011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD: total 10 cycles. IRWrite is 1 for exactly 1 cycle. memRead is held for the whole MEM_RD. regWrite occurs in MEM_WB with resultSrc=01.
- SW (op=0100011) with mem_ready low for 1 cycle in MEM_WR: memWrite=1 for 2 consecutive cycles with adrSrc=1 and immSrc=001 in EX_S. Total 5 cycles, instret+1.
- JALR (op=1100111), ENABLE_JALR=1: PCUpdate=1 in EX_JR with A=10/B=01, then LINK_WB with A=01/B=10 and regWrite=1. Repeat with ENABLE_JALR=0, TRAP_ON_ILLEGAL=1: halted=1 and illegal=1 from cycle 3 onward, no strobes, instret unchanged.
- Illegal op=1111111 with TRAP_ON_ILLEGAL=0: illegal pulses for 1 cycle in DECODE, return to FETCH, instret+1. Then pull rst=0 during MEM_RD of a following load: state=FETCH, instret=0, memRead/regWrite low, asynchronously.
- CNT_W=4: execute 17 LUI (op=0110111) instructions at 3 cycles each: instret reads 1 after the wrap (16 -> 0), and regWrite=1 with resultSrc=11 and immSrc=100 on every EX_U.
